video_timing_gen: RTL and testbench

- Raster timing generator feeding the core's pixel/pattern stage, which then drives the VGA_* outputs and CE_PIXEL.
- Produces the pixel-clock enable, beam coordinates, blanking and sync for an NTSC (262-line) or PAL (312-line) 15 kHz raster.
- Optionally runs at 31 kHz line-doubled rate when the scandoubler is forced.
- All outputs are registered and mutually aligned, so downstream logic only has to qualify with ce_pix.

---
 rtl/video_timing_pkg.sv | 18 +
 rtl/video_timing_gen_ce_divider.sv | 30 +++
 rtl/video_timing_gen.sv | 93 +++++++++
 tb/tb_video_timing_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: raster constants and latched mode type shared by the timing generator
package video_timing_pkg;
  localparam int NTSC_V_TOTAL = 262;
  localparam int PAL_V_TOTAL = 312;
  localparam int NTSC_VS_START = 244;
  localparam int PAL_VS_START = 270;
  localparam int VS_LINES = 3;
  localparam int DEF_CE_DIV = 8;
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 32;
  localparam int DEF_H_BP = 16;
  localparam int DEF_V_ACTIVE = 240;
  typedef struct packed {
    logic pal;
    logic dbl;
  } mode_t;
endpackage

// File: rtl/video_timing_gen_ce_divider.sv
// ce_divider: free-running clk divider giving a pixel tick one cycle ahead of ce_pix
module ce_divider #(
  parameter int CE_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic half,
  output logic ce
);
  localparam int W = $clog2(CE_DIV);
  logic [W-1:0] div_cnt_q, div_cnt_d, last;
  logic ce_q, ce_d;
  // wrap at the active period; flag the count before the terminal one so the parent advances together with ce_pix
  always_comb begin
    last = half ? W'(CE_DIV / 2 - 1) : W'(CE_DIV - 1);
    div_cnt_d = div_cnt_q >= last ? '0 : div_cnt_q + 1'b1;
    ce_d = div_cnt_q == last - 1'b1;
  end
  // divider state, phase restarts on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      ce_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      ce_q <= ce_d;
    end
  end
  assign ce = ce_q;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: 15/31 kHz NTSC/PAL raster timing with registered, ce_pix-aligned outputs
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CE_DIV = DEF_CE_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pal,
  input  logic       scandouble,
  output logic       ce_pix,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       line_rep,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END = HS_START + H_SYNC;
  logic ce;
  mode_t mode_q, mode_d;
  logic [8:0] h_q, h_d, v_q, v_d, v_last, vs_first;
  logic rep_q, rep_d, ce_pix_q, hb_q, hb_d, hs_q, hs_d, vb_q, vb_d, vs_q, vs_d, fs_q, fs_d;
  logic h_end, rep_first, v_adv, v_end;
  ce_divider #(.CE_DIV(CE_DIV)) u_div (
    .clk(clk),
    .reset(reset),
    .half(mode_q.dbl),
    .ce(ce)
  );
  // next beam position and decodes; decodes follow the next counters so they stay aligned with them
  always_comb begin
    v_last = mode_q.pal ? 9'(PAL_V_TOTAL - 1) : 9'(NTSC_V_TOTAL - 1);
    vs_first = mode_q.pal ? 9'(PAL_VS_START) : 9'(NTSC_VS_START);
    h_end = h_q == 9'(H_TOTAL - 1);
    rep_first = mode_q.dbl & ~rep_q;
    v_adv = ce & h_end & ~rep_first;
    v_end = v_adv & (v_q == v_last);
    h_d = !ce ? h_q : h_end ? '0 : h_q + 9'd1;
    rep_d = ce & h_end ? rep_first : rep_q;
    v_d = !v_adv ? v_q : v_end ? '0 : v_q + 9'd1;
    mode_d = v_end ? mode_t'({pal, scandouble}) : mode_q;
    hb_d = h_d >= 9'(H_ACTIVE);
    hs_d = h_d >= 9'(HS_START) && h_d < 9'(HS_END);
    vb_d = v_d >= 9'(V_ACTIVE);
    vs_d = v_d >= vs_first && v_d < vs_first + 9'(VS_LINES);
    fs_d = ce && h_d == '0 && v_d == '0 && !rep_d;
  end
  // raster state; the mode is reloaded from the pins while reset is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= mode_t'({pal, scandouble});
      h_q <= '0;
      v_q <= '0;
      rep_q <= 1'b0;
      ce_pix_q <= 1'b0;
      hb_q <= 1'b0;
      hs_q <= 1'b0;
      vb_q <= 1'b0;
      vs_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      h_q <= h_d;
      v_q <= v_d;
      rep_q <= rep_d;
      ce_pix_q <= ce;
      hb_q <= hb_d;
      hs_q <= hs_d;
      vb_q <= vb_d;
      vs_q <= vs_d;
      fs_q <= fs_d;
    end
  end
  assign ce_pix = ce_pix_q;
  assign hcount = h_q;
  assign vcount = v_q;
  assign line_rep = rep_q;
  assign HBlank = hb_q;
  assign HSync = hs_q;
  assign VBlank = vb_q;
  assign VSync = vs_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: full-size horizontal checks plus a shrunk-line instance for whole-frame runs
module tb_video_timing_gen;
  localparam int SD = 4, SA = 4, SF = 1, SS = 2, SB = 1, SHT = 8;
  typedef struct packed {
    logic ce;
    logic [8:0] h;
    logic [8:0] v;
    logic rep, hb, hs, vb, vs, fs;
  } obs_t;
  typedef struct {
    int k;
    int h;
    int v;
    int hb;
    int hs;
  } row_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic f_rst = 1, f_pal = 0, f_sd = 0;
  logic f_ce, f_rep, f_hb, f_hs, f_vb, f_vs, f_fs;
  logic [8:0] f_h, f_v;
  logic s_rst = 1, s_pal = 0, s_sd = 0;
  logic s_ce, s_rep, s_hb, s_hs, s_vb, s_vs, s_fs;
  logic [8:0] s_h, s_v;
  video_timing_gen u_full (
    .clk(clk), .reset(f_rst), .pal(f_pal), .scandouble(f_sd), .ce_pix(f_ce), .hcount(f_h), .vcount(f_v),
    .line_rep(f_rep), .HBlank(f_hb), .HSync(f_hs), .VBlank(f_vb), .VSync(f_vs), .frame_start(f_fs)
  );
  video_timing_gen #(.CE_DIV(SD), .H_ACTIVE(SA), .H_FP(SF), .H_SYNC(SS), .H_BP(SB)) u_small (
    .clk(clk), .reset(s_rst), .pal(s_pal), .scandouble(s_sd), .ce_pix(s_ce), .hcount(s_h), .vcount(s_v),
    .line_rep(s_rep), .HBlank(s_hb), .HSync(s_hs), .VBlank(s_vb), .VSync(s_vs), .frame_start(s_fs)
  );
  int checks = 0, errors = 0;
  obs_t exp_q[$];
  obs_t m;
  int ph, n;
  logic mp, md;
  int tot_ce, prev_v, vs_lo, vs_hi, vs_ce, vb_lo, vb_hi, rep_lines;
  int wraps[$];
  int fs_at[$];
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask
  function automatic obs_t s_obs();
    return {s_ce, s_h, s_v, s_rep, s_hb, s_hs, s_vb, s_vs, s_fs};
  endfunction
  // linear pixel-index model of the small instance: position within the frame gives every output
  task automatic model_tick();
    int ol, vs0;
    if (s_rst) begin
      ph = 0; n = 0; mp = s_pal; md = s_sd; m = '0;
    end else begin
      ph++;
      m.ce = 0;
      m.fs = 0;
      if (ph == (md ? SD / 2 : SD)) begin
        ph = 0;
        n++;
        if (n == SHT * (mp ? 312 : 262) * (md ? 2 : 1)) begin
          n = 0; mp = s_pal; md = s_sd;
        end
        ol = n / SHT;
        vs0 = mp ? 270 : 244;
        m.ce = 1;
        m.h = 9'(n % SHT);
        m.v = 9'(md ? ol / 2 : ol);
        m.rep = md & ol[0];
        m.hb = m.h >= SA;
        m.hs = m.h >= SA + SF && m.h < SA + SF + SS;
        m.vb = m.v >= 240;
        m.vs = m.v >= vs0 && m.v < vs0 + 3;
        m.fs = n == 0;
      end
    end
    exp_q.push_back(m);
  endtask
  task automatic step();
    obs_t e, a;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    e = exp_q.pop_front();
    a = s_obs();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL sb t=%0t actual %h required %h", $time, a, e);
    end
  endtask
  task automatic run_ce(input int cnt);
    int seen = 0, guard = 0;
    wraps.delete(); fs_at.delete();
    vs_lo = 999; vs_hi = -1; vs_ce = 0; vb_lo = 999; vb_hi = -1; rep_lines = 0;
    while (seen < cnt && guard < cnt * SD + 16) begin
      step();
      guard++;
      if (s_ce) begin
        seen++;
        tot_ce++;
        if (s_v == 0 && prev_v != 0) wraps.push_back(prev_v);
        prev_v = int'(s_v);
        if (s_vs) begin
          vs_ce++;
          if (int'(s_v) < vs_lo) vs_lo = int'(s_v);
          if (int'(s_v) > vs_hi) vs_hi = int'(s_v);
        end
        if (s_vb) begin
          if (int'(s_v) < vb_lo) vb_lo = int'(s_v);
          if (int'(s_v) > vb_hi) vb_hi = int'(s_v);
        end
        if (s_rep && s_h == 0) rep_lines++;
        if (s_fs) fs_at.push_back(tot_ce);
      end
    end
    chk("run_len", seen, cnt);
  endtask
  initial begin
    row_t rows[9];
    int k, st, hs_n;
    rows = '{'{1, 1, 0, 0, 0}, '{319, 319, 0, 0, 0}, '{320, 320, 0, 1, 0}, '{335, 335, 0, 1, 0},
             '{336, 336, 0, 1, 1}, '{367, 367, 0, 1, 1}, '{368, 368, 0, 1, 0}, '{383, 383, 0, 1, 0},
             '{384, 0, 1, 0, 0}};
    repeat (3) step();
    chk("f_reset", int'({f_ce, f_h, f_v, f_rep, f_hb, f_hs, f_vb, f_vs, f_fs}), 0);
    f_rst = 0;
    k = 0; st = 0; hs_n = 0;
    for (int i = 0; i < 9; i++) begin
      while (k < rows[i].k && st < 8 * rows[i].k + 16) begin
        step();
        st++;
        if (f_ce) begin
          k++;
          if (f_hs) hs_n++;
        end
      end
      chk("f_clk", st, 8 * rows[i].k);
      chk("f_h", int'(f_h), rows[i].h);
      chk("f_v", int'(f_v), rows[i].v);
      chk("f_hb", int'(f_hb), rows[i].hb);
      chk("f_hs", int'(f_hs), rows[i].hs);
    end
    chk("f_hs_len", hs_n, 32);
    while (k < 584 && st < 8 * 584 + 16) begin
      step();
      st++;
      if (f_ce) k++;
    end
    chk("f_pre_rst_h", int'(f_h), 200);
    #1 f_rst = 1;
    #1 chk("f_rst_async", int'({f_ce, f_h, f_v, f_rep, f_hb, f_hs, f_vb, f_vs, f_fs}), 0);
    repeat (2) step();
    f_rst = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("f_ce_phase", int'(f_ce), int'(i == 8));
    end
    chk("f_h_after_rst", int'(f_h), 1);
    chk("f_v_after_rst", int'(f_v), 0);
    s_rst = 0; tot_ce = 0; prev_v = 0;
    run_ce(1200);
    chk("s_pre_rst_v", int'(s_v), 150);
    #1 s_rst = 1;
    #1 chk("s_rst_async", int'(s_obs()), 0);
    repeat (2) step();
    s_rst = 0; tot_ce = 0; prev_v = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (s_ce) tot_ce++;
      chk("s_ce_phase", int'(s_ce), int'(i == 4));
    end
    chk("s_h_after_rst", int'(s_h), 1);
    chk("s_v_after_rst", int'(s_v), 0);
    run_ce(2895);
    chk("ntsc_wraps", wraps.size(), 1);
    chk("ntsc_wrap_v", wraps[0], 261);
    chk("ntsc_vs_lo", vs_lo, 244);
    chk("ntsc_vs_hi", vs_hi, 246);
    chk("ntsc_vs_len", vs_ce, 3 * SHT);
    chk("ntsc_vb_lo", vb_lo, 240);
    chk("ntsc_vb_hi", vb_hi, 261);
    chk("ntsc_fs_n", fs_at.size(), 1);
    chk("ntsc_fs_at", fs_at[0], 262 * SHT);
    chk("toggle_v", int'(s_v), 100);
    s_pal = 1;
    run_ce(1296);
    chk("toggle_wrap_v", wraps[0], 261);
    chk("toggle_fs_at", fs_at[0], 2 * 262 * SHT);
    run_ce(2496);
    chk("pal_wraps", wraps.size(), 1);
    chk("pal_wrap_v", wraps[0], 311);
    chk("pal_vs_lo", vs_lo, 270);
    chk("pal_vs_hi", vs_hi, 272);
    chk("pal_vs_len", vs_ce, 3 * SHT);
    chk("pal_vb_lo", vb_lo, 240);
    chk("pal_vb_hi", vb_hi, 311);
    chk("pal_fs_at", fs_at[0], 2 * 262 * SHT + 312 * SHT);
    #1 s_rst = 1;
    s_pal = 0;
    s_sd = 1;
    repeat (2) step();
    s_rst = 0; tot_ce = 0; prev_v = 0;
    for (int i = 1; i <= 2; i++) begin
      step();
      if (s_ce) tot_ce++;
      chk("dbl_ce_phase", int'(s_ce), int'(i == 2));
    end
    run_ce(524 * SHT - 1);
    chk("dbl_wrap_v", wraps[0], 261);
    chk("dbl_vs_lo", vs_lo, 244);
    chk("dbl_vs_hi", vs_hi, 246);
    chk("dbl_vs_lines", vs_ce, 6 * SHT);
    chk("dbl_rep_lines", rep_lines, 262);
    chk("dbl_fs_n", fs_at.size(), 1);
    chk("dbl_fs_at", fs_at[0], 524 * SHT);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
